// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// Optional err / misalign_seen signals exist only when DMEM_ARB_ALIGN_CHECK_EN is defined.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              r0_valid;
  logic              r0_ready;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              busy;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic              r0_err;
  logic              r1_err;
  logic              misalign_seen;
`endif

  // Arbiter side: accepts requests, drives the memory.
  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    input  read_data,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_read, mem_write, address, write_data, busy
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    , output r0_err, r1_err, misalign_seen
`endif
  );

  // Environment side: requesters plus the memory.
  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    output read_data,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_read, mem_write, address, write_data, busy
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    , input r0_err, r1_err, misalign_seen
`endif
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the single-port data memory.
// Define DMEM_ARB_ALIGN_CHECK_EN to suppress and flag misaligned (addr[1:0] != 0) accesses.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              outside_reset,
  dmem_arbiter_if.slave     bus
);

  typedef enum logic {IDLE, RESP} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;

  logic              winner;
  logic              grant_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;
  logic [DATA_W-1:0] rsp_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    winner = 1'b0;
    if (bus.r0_valid && bus.r1_valid) winner = ~last_grant_q;
    else if (bus.r1_valid)            winner = 1'b1;
  end

  // Reset gates arbitration so nothing is granted in a reset cycle.
  assign grant_any = (state_q == IDLE) && !outside_reset && (bus.r0_valid || bus.r1_valid);
  assign sel_we    = winner ? bus.r1_we    : bus.r0_we;
  assign sel_addr  = winner ? bus.r1_addr  : bus.r0_addr;
  assign sel_wdata = winner ? bus.r1_wdata : bus.r0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misaligned = sel_addr[1:0] != 2'b00;
  assign rsp_data   = misaligned ? '0 : bus.read_data;
`else
  assign misaligned = 1'b0;
  assign rsp_data   = bus.read_data;
`endif

  assign bus.r0_ready   = grant_any && !winner;
  assign bus.r1_ready   = grant_any &&  winner;
  assign bus.mem_write  = grant_any &&  sel_we && !misaligned;
  assign bus.mem_read   = grant_any && !sel_we && !misaligned;
  // Without a grant the memory keeps seeing the last granted address/data.
  assign bus.address    = grant_any ? sel_addr  : addr_q;
  assign bus.write_data = grant_any ? sel_wdata : wdata_q;

  assign bus.r0_rvalid  = r0_rvalid_q;
  assign bus.r1_rvalid  = r1_rvalid_q;
  assign bus.r0_rdata   = r0_rdata_q;
  assign bus.r1_rdata   = r1_rdata_q;
  assign bus.busy       = busy_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (outside_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      r0_rvalid_q  <= 1'b0;
      r1_rvalid_q  <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      busy_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            last_grant_q <= winner;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            if (!sel_we) begin
              state_q <= RESP;
              busy_q  <= 1'b1;
              if (winner) begin
                r1_rvalid_q <= 1'b1;
                r1_rdata_q  <= rsp_data;
              end else begin
                r0_rvalid_q <= 1'b1;
                r0_rdata_q  <= rsp_data;
              end
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic err_q;
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (outside_reset) begin
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (grant_any) begin
        err_q      <= misaligned && !sel_we;
        misalign_q <= misalign_q || misaligned;
      end
    end
  end

  // Read errors ride with rvalid; write errors pulse with ready.
  assign bus.r0_err = (r0_rvalid_q && err_q) || (bus.r0_ready && sel_we && misaligned);
  assign bus.r1_err = (r1_rvalid_q && err_q) || (bus.r1_ready && sel_we && misaligned);
  assign bus.misalign_seen = misalign_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 32-word async-read memory.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

  logic clk;
  logic outside_reset;
  logic [31:0] mem [32];
  int checks;
  int failures;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .outside_reset (outside_reset),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.read_data = mem[bus.address[6:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.address[6:2]] <= bus.write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_r0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic set_r1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  task automatic do_reset();
    outside_reset = 1'b1;
    step();
    outside_reset = 1'b0;
  endtask

  initial begin
    int n0, n1;
    logic exp_w;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[16] = 32'h1111_4040;
    mem[17] = 32'h2222_4444;
    outside_reset = 1'b1;
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    step();
    step();

    // Reset state
    check("rst_r0_rvalid", bus.r0_rvalid, 0);
    check("rst_r1_rvalid", bus.r1_rvalid, 0);
    check("rst_r0_rdata", bus.r0_rdata, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
    outside_reset = 1'b0;

    // Write then read back through r0
    set_r0(1, 1, 32'h4, 32'hDEAD_BEEF);
    #1;
    check("w_r0_ready", bus.r0_ready, 1);
    check("w_mem_write", bus.mem_write, 1);
    check("w_address", bus.address, 32'h4);
    check("w_wdata", bus.write_data, 32'hDEAD_BEEF);
    step();
    set_r0(1, 0, 32'h4, 0);
    #1;
    check("rd_r0_ready", bus.r0_ready, 1);
    check("rd_mem_rw", {bus.mem_read, bus.mem_write}, 2'b10);
    step();
    set_r0(0, 0, 32'h4, 0);
    #1;
    check("rsp_r0_rvalid", bus.r0_rvalid, 1);
    check("rsp_r0_rdata", bus.r0_rdata, 32'hDEAD_BEEF);
    check("rsp_busy", bus.busy, 1);
    check("rsp_r1_rvalid", bus.r1_rvalid, 0);
    check("rsp_mem_read", bus.mem_read, 0);
    check("rsp_addr_hold", bus.address, 32'h4);
    step();
    #1;
    check("post_r0_rvalid", bus.r0_rvalid, 0);
    check("post_rdata_hold", bus.r0_rdata, 32'hDEAD_BEEF);
    check("post_busy", bus.busy, 0);

    // Continuous write contention after reset: 0,1,0,1,0,1
    step();
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      set_r0(1, 1, 32'h10 + 32'(4 * n0), 32'hA000_0000 + 32'(n0));
      set_r1(1, 1, 32'h20 + 32'(4 * n1), 32'hB000_0000 + 32'(n1));
      exp_w = (i % 2) == 1;
      #1;
      check($sformatf("rr%0d_ready", i), {bus.r0_ready, bus.r1_ready}, exp_w ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_mem_write", i), bus.mem_write, 1);
      check($sformatf("rr%0d_addr", i), bus.address,
            exp_w ? 32'h20 + 32'(4 * n1) : 32'h10 + 32'(4 * n0));
      if (exp_w) n1++; else n0++;
      step();
    end
    set_r0(0, 0, 0, 0);
    set_r1(0, 0, 0, 0);
    check("rr_mem_r0_last", mem[6], 32'hA000_0002);
    check("rr_mem_r1_last", mem[10], 32'hB000_0002);

    // Back-to-back r1 reads: mem_read 1,0,1,0
    set_r1(1, 0, 32'h40, 0);
    #1;
    check("b2b_c1_read", {bus.mem_read, bus.r1_ready}, 2'b11);
    step();
    set_r1(1, 0, 32'h44, 0);
    #1;
    check("b2b_c2_read", {bus.mem_read, bus.r1_ready}, 2'b00);
    check("b2b_c2_rvalid", bus.r1_rvalid, 1);
    check("b2b_c2_rdata", bus.r1_rdata, 32'h1111_4040);
    step();
    #1;
    check("b2b_c3_read", {bus.mem_read, bus.r1_ready}, 2'b11);
    check("b2b_c3_rvalid", bus.r1_rvalid, 0);
    step();
    set_r1(0, 0, 32'h44, 0);
    #1;
    check("b2b_c4_read", bus.mem_read, 0);
    check("b2b_c4_rvalid", bus.r1_rvalid, 1);
    check("b2b_c4_rdata", bus.r1_rdata, 32'h2222_4444);
    step();

    // r0 read accepted while r1 write waits through RESP
    set_r0(1, 0, 32'h40, 0);
    set_r1(1, 1, 32'h30, 32'h0000_0055);
    #1;
    check("wait_c1_ready", {bus.r0_ready, bus.r1_ready}, 2'b10);
    step();
    set_r0(0, 0, 32'h40, 0);
    #1;
    check("wait_c2_ready", {bus.r0_ready, bus.r1_ready}, 2'b00);
    check("wait_c2_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b10);
    check("wait_c2_rdata", bus.r0_rdata, 32'h1111_4040);
    check("wait_c2_mem_write", bus.mem_write, 0);
    step();
    #1;
    check("wait_c3_r1_ready", bus.r1_ready, 1);
    check("wait_c3_mem_write", bus.mem_write, 1);
    check("wait_c3_addr", bus.address, 32'h30);
    check("wait_c3_rvalid", {bus.r0_rvalid, bus.r1_rvalid}, 2'b00);
    step();
    set_r1(0, 0, 0, 0);
    check("wait_mem", mem[12], 32'h0000_0055);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    // Misaligned r1 read is granted but never reaches the memory
    set_r1(1, 0, 32'h6, 0);
    #1;
    check("mis_r1_ready", bus.r1_ready, 1);
    check("mis_mem_read", bus.mem_read, 0);
    step();
    set_r1(0, 0, 0, 0);
    #1;
    check("mis_rvalid", bus.r1_rvalid, 1);
    check("mis_err", bus.r1_err, 1);
    check("mis_rdata", bus.r1_rdata, 0);
    check("mis_seen", bus.misalign_seen, 1);
    step();
    step();
    #1;
    check("mis_err_drop", bus.r1_err, 0);
    check("mis_seen_sticky", bus.misalign_seen, 1);
    step();
`endif

    // Reset during RESP drops the response; r0 wins first afterwards
    set_r0(1, 0, 32'h44, 0);
    #1;
    check("rr_c1_r0_ready", bus.r0_ready, 1);
    step();
    set_r0(1, 1, 32'h50, 32'h0000_0050);
    set_r1(1, 1, 32'h54, 32'h0000_0054);
    outside_reset = 1'b1;
    #1;
    check("rstr_busy", bus.busy, 1);
    check("rstr_ready_resp", {bus.r0_ready, bus.r1_ready}, 2'b00);
    step();
    #1;
    check("rstr_rvalid_dropped", bus.r0_rvalid, 0);
    check("rstr_no_grant", {bus.r0_ready, bus.r1_ready}, 2'b00);
    check("rstr_rdata_clr", bus.r0_rdata, 0);
    check("rstr_busy_clr", bus.busy, 0);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check("rstr_mis_clr", bus.misalign_seen, 0);
`endif
    step();
    outside_reset = 1'b0;
    #1;
    check("rstr_first_r0", {bus.r0_ready, bus.r1_ready}, 2'b10);
    check("rstr_first_addr", bus.address, 32'h50);
    step();
    set_r0(0, 0, 0, 0);
    #1;
    check("rstr_second_r1", {bus.r0_ready, bus.r1_ready}, 2'b01);
    step();
    set_r1(0, 0, 0, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
